// File: rtl/branch_history_predictor.sv
// Branch direction predictor: table of saturating counters indexed by PC (bimodal)
// or PC XOR global history (gshare), with speculative GHR update and mispredict repair.
package branch_history_predictor_pkg;
  typedef enum logic {NOTTAKEN = 1'b0, TAKEN = 1'b1} predictmux_t;
  typedef logic [31:0] rv32i_word;
endpackage

module branch_history_predictor
  import branch_history_predictor_pkg::*;
#(
  parameter int unsigned S_INDEX   = 7,
  parameter int unsigned CTR_WIDTH = 2,
  parameter int unsigned HIST_LEN  = 7,
  parameter int unsigned GSHARE    = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                predict_en,
  input  rv32i_word           curr_pc,
  output predictmux_t         predicted_direction,
  output logic [HIST_LEN-1:0] pred_hist,
  input  logic                update_en,
  input  rv32i_word           resolved_pc,
  input  logic [HIST_LEN-1:0] resolved_hist,
  input  logic                resolved_taken,
  input  logic                mispredict
);

  localparam int unsigned            DEPTH    = 1 << S_INDEX;
  localparam logic [CTR_WIDTH-1:0]   CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0]   CTR_ZERO = '0;
  localparam logic [CTR_WIDTH-1:0]   CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);

  logic [CTR_WIDTH-1:0] r_ctr [DEPTH];
  logic [HIST_LEN-1:0]  r_ghr;

  logic [S_INDEX-1:0]   w_pi_hist;
  logic [S_INDEX-1:0]   w_ui_hist;
  logic [S_INDEX-1:0]   w_pi;
  logic [S_INDEX-1:0]   w_ui;
  logic [CTR_WIDTH-1:0] w_pred_ctr;
  logic [CTR_WIDTH-1:0] w_upd_ctr;
  logic [CTR_WIDTH-1:0] w_next_ctr;
  logic                 w_pred_bit;
  logic [HIST_LEN-1:0]  w_repair_hist;
  logic [HIST_LEN-1:0]  w_spec_hist;
  logic                 w_unused;

  // History folds into the low index bits only in gshare mode
  always_comb begin
    w_pi_hist = '0;
    w_ui_hist = '0;
    if (GSHARE != 0) begin
      w_pi_hist = S_INDEX'(r_ghr);
      w_ui_hist = S_INDEX'(resolved_hist);
    end
  end

  assign w_pi = curr_pc[2 +: S_INDEX] ^ w_pi_hist;
  assign w_ui = resolved_pc[2 +: S_INDEX] ^ w_ui_hist;

  assign w_pred_ctr          = r_ctr[w_pi];
  assign w_pred_bit          = w_pred_ctr[CTR_WIDTH-1];
  assign predicted_direction = w_pred_bit ? TAKEN : NOTTAKEN;
  assign pred_hist           = r_ghr;

  // Saturating step of the trained counter
  assign w_upd_ctr = r_ctr[w_ui];
  always_comb begin
    w_next_ctr = w_upd_ctr;
    if (resolved_taken) begin
      if (w_upd_ctr != CTR_MAX) w_next_ctr = w_upd_ctr + CTR_WIDTH'(1);
    end else begin
      if (w_upd_ctr != CTR_ZERO) w_next_ctr = w_upd_ctr - CTR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_ctr[i] <= CTR_INIT;
    end else if (update_en) begin
      r_ctr[w_ui] <= w_next_ctr;
    end
  end

  // Truncation drops the oldest bit; also covers HIST_LEN = 1
  assign w_repair_hist = HIST_LEN'({resolved_hist, resolved_taken});
  assign w_spec_hist   = HIST_LEN'({r_ghr, w_pred_bit});

  // Repair outranks the speculative shift: the co-issued fetch is being flushed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ghr <= '0;
    end else if (update_en && mispredict) begin
      r_ghr <= w_repair_hist;
    end else if (predict_en) begin
      r_ghr <= w_spec_hist;
    end
  end

  assign w_unused = ^{curr_pc[1:0], curr_pc[31:S_INDEX+2],
                      resolved_pc[1:0], resolved_pc[31:S_INDEX+2], w_pred_ctr};

endmodule

// File: tb/tb_branch_history_predictor.sv
// Directed bench: gshare, bimodal and 3-bit-counter instances share one stimulus stream.
module tb_branch_history_predictor;
  import branch_history_predictor_pkg::*;

  localparam logic [31:0] T = 32'd1;
  localparam logic [31:0] N = 32'd0;

  logic        clk;
  logic        rst;
  logic        predict_en;
  rv32i_word   curr_pc;
  logic        update_en;
  rv32i_word   resolved_pc;
  logic [3:0]  resolved_hist;
  logic        resolved_taken;
  logic        mispredict;

  predictmux_t pd_gs, pd_bi, pd_c3;
  logic [3:0]  ph_gs, ph_bi, ph_c3;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  branch_history_predictor #(.S_INDEX(7), .CTR_WIDTH(2), .HIST_LEN(4), .GSHARE(1)) u_gs (
    .clk(clk), .rst(rst), .predict_en(predict_en), .curr_pc(curr_pc),
    .predicted_direction(pd_gs), .pred_hist(ph_gs), .update_en(update_en),
    .resolved_pc(resolved_pc), .resolved_hist(resolved_hist),
    .resolved_taken(resolved_taken), .mispredict(mispredict));

  branch_history_predictor #(.S_INDEX(7), .CTR_WIDTH(2), .HIST_LEN(4), .GSHARE(0)) u_bi (
    .clk(clk), .rst(rst), .predict_en(predict_en), .curr_pc(curr_pc),
    .predicted_direction(pd_bi), .pred_hist(ph_bi), .update_en(update_en),
    .resolved_pc(resolved_pc), .resolved_hist(resolved_hist),
    .resolved_taken(resolved_taken), .mispredict(mispredict));

  branch_history_predictor #(.S_INDEX(7), .CTR_WIDTH(3), .HIST_LEN(4), .GSHARE(0)) u_c3 (
    .clk(clk), .rst(rst), .predict_en(predict_en), .curr_pc(curr_pc),
    .predicted_direction(pd_c3), .pred_hist(ph_c3), .update_en(update_en),
    .resolved_pc(resolved_pc), .resolved_hist(resolved_hist),
    .resolved_taken(resolved_taken), .mispredict(mispredict));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    predict_en     = 1'b0;
    update_en      = 1'b0;
    mispredict     = 1'b0;
    resolved_taken = 1'b0;
    resolved_hist  = 4'h0;
    resolved_pc    = 32'h0;
    curr_pc        = 32'h0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    tick();
  endtask

  task automatic upd(input logic [31:0] pc, input logic [3:0] hist, input logic tk,
                     input logic mp);
    update_en      = 1'b1;
    resolved_pc    = pc;
    resolved_hist  = hist;
    resolved_taken = tk;
    mispredict     = mp;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #1;
    chk("rst0_pd_gs", 32'(pd_gs), N);
    chk("rst0_ph_gs", 32'(ph_gs), 32'h0);
    chk("rst0_ph_bi", 32'(ph_bi), 32'h0);
    chk("rst0_pd_c3", 32'(pd_c3), N);
    chk("rst0_ph_c3", 32'(ph_c3), 32'h0);
    tick();
    rst = 1'b1;
    tick();

    // Bimodal saturation at PC 0x40
    curr_pc = 32'h40;
    upd(32'h40, 4'h0, 1'b1, 1'b0);
    #1;
    chk("sat_c1", 32'(pd_bi), N);
    tick(); chk("sat_inc_c2", 32'(pd_bi), T);
    tick(); chk("sat_inc_c3", 32'(pd_bi), T);
    tick(); chk("sat_inc_hold3", 32'(pd_bi), T);
    resolved_taken = 1'b0;
    tick(); chk("sat_dec_c2", 32'(pd_bi), T);
    tick(); chk("sat_dec_c1", 32'(pd_bi), N);
    tick(); chk("sat_dec_c0", 32'(pd_bi), N);
    tick(); chk("sat_dec_hold0", 32'(pd_bi), N);
    resolved_taken = 1'b1;
    tick(); chk("sat_after0_c1", 32'(pd_bi), N);
    tick(); chk("sat_after0_c2", 32'(pd_bi), T);
    do_reset();

    // Speculative history on gshare
    upd(32'h14, 4'h0, 1'b1, 1'b0);
    tick();
    idle();
    predict_en = 1'b1;
    curr_pc    = 32'h14;
    #1;
    chk("spec_pd0", 32'(pd_gs), T);
    chk("spec_ph0", 32'(ph_gs), 32'h0);
    tick();
    chk("spec_ph1", 32'(ph_gs), 32'h1);
    chk("spec_pd1", 32'(pd_gs), N);
    tick();
    chk("spec_ph2", 32'(ph_gs), 32'h2);
    idle();

    // Mispredict repair with a colliding predict
    upd(32'h0, 4'h5, 1'b1, 1'b1);
    tick();
    chk("rep_set_1011", 32'(ph_gs), 32'hB);
    upd(32'h0, 4'h6, 1'b1, 1'b1);
    predict_en = 1'b1;
    curr_pc    = 32'h100;
    tick();
    chk("rep_ghr_1101", 32'(ph_gs), 32'hD);
    upd(32'h0, 4'h5, 1'b1, 1'b1);
    predict_en = 1'b0;
    tick();
    chk("rep_reset_1011", 32'(ph_gs), 32'hB);
    upd(32'h0, 4'h6, 1'b1, 1'b0);
    predict_en = 1'b1;
    curr_pc    = 32'h100;
    #1;
    chk("nomp_pd", 32'(pd_gs), N);
    tick();
    chk("nomp_ghr_0110", 32'(ph_gs), 32'h6);
    predict_en = 1'b0;
    tick();
    chk("upd_only_hold", 32'(ph_gs), 32'h6);
    idle();

    // Asynchronous reset mid-run; index 3^6 = 5 is trained taken
    curr_pc = 32'h0C;
    #1;
    chk("pre_rst_pd", 32'(pd_gs), T);
    rst = 1'b0;
    #1;
    chk("async_rst_pd", 32'(pd_gs), N);
    chk("async_rst_ph", 32'(ph_gs), 32'h0);
    for (int i = 0; i < 4; i++) begin
      curr_pc = 32'h14 + 32'(i) * 32'h44;
      #1;
      chk("async_rst_pd_sweep", 32'(pd_gs), N);
    end
    upd(32'h14, 4'h0, 1'b1, 1'b1);
    predict_en = 1'b1;
    curr_pc    = 32'h14;
    tick();
    tick();
    chk("rst_ignore_pd", 32'(pd_gs), N);
    chk("rst_ignore_ph", 32'(ph_gs), 32'h0);
    idle();
    #1;
    rst = 1'b1;
    tick();

    // Same-index collision: no bypass
    curr_pc = 32'h20;
    upd(32'h20, 4'h0, 1'b1, 1'b0);
    #1;
    chk("coll_same_cycle", 32'(pd_gs), N);
    tick();
    idle();
    curr_pc = 32'h20;
    #1;
    chk("coll_next_cycle", 32'(pd_gs), T);
    do_reset();

    // 3-bit counters: reset 3, saturate at 7
    curr_pc = 32'h40;
    #1;
    chk("c3_reset", 32'(pd_c3), N);
    upd(32'h40, 4'h0, 1'b1, 1'b0);
    tick();
    chk("c3_c4", 32'(pd_c3), T);
    for (int i = 0; i < 7; i++) tick();
    chk("c3_c7", 32'(pd_c3), T);
    resolved_taken = 1'b0;
    tick(); tick(); tick();
    chk("c3_dec_c4", 32'(pd_c3), T);
    tick();
    chk("c3_dec_c3", 32'(pd_c3), N);
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
